// File: rtl/ingress_command_sequencer.sv
// ingress_command_sequencer
// Splits one fetch job (base address, total length, chunk size) into a series
// of read-command packets. It issues one command at a time to the ingress
// interface command port, then snoops that interface's response handshake
// and counts returned data beats until the chunk is complete. When the last
// chunk has fully returned it pulses job_done.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   job_start         one-cycle start pulse, only honoured while idle
//   job_base_addr     first byte address of the job
//   job_total_len     total bytes to fetch
//   job_chunk_len     maximum bytes carried by one command
//   job_busy          high from accepted start until the done pulse
//   job_done          one-cycle pulse when the last chunk has returned
//   job_error         one-cycle pulse when a start is rejected (zero length)
//   cmd_valid         command packet valid (drives ext_input_valid)
//   cmd_accept        command accepted (from ext_input_accept)
//   cmd_payload       [127:64] address, [63:28] length, all other bits 0
//   rsp_valid         snooped ext_output_valid
//   rsp_accept        snooped ext_output_accept
module ingress_command_sequencer #(
  parameter int C_PACKET_WIDTH    = 128,
  parameter int C_BEAT_BYTES_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_start,
  input  logic [63:0]               job_base_addr,
  input  logic [35:0]               job_total_len,
  input  logic [35:0]               job_chunk_len,
  output logic                      job_busy,
  output logic                      job_done,
  output logic                      job_error,
  output logic                      cmd_valid,
  input  logic                      cmd_accept,
  output logic [C_PACKET_WIDTH-1:0] cmd_payload,
  input  logic                      rsp_valid,
  input  logic                      rsp_accept
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_ISSUE    = 4'b0010,
    ST_WAIT_RSP = 4'b0100,
    ST_DONE     = 4'b1000
  } state_t;

  // Added to a byte length before shifting so partial beats round up.
  localparam logic [36:0] BEAT_ROUND = (37'd1 << C_BEAT_BYTES_LOG2) - 37'd1;

  state_t      state_r;
  logic [63:0] addr_r;
  logic [35:0] remaining_r;
  logic [35:0] chunk_r;
  logic [35:0] cur_len_r;
  logic [36:0] beats_expected_r;
  logic [36:0] beats_seen_r;

  logic [35:0] cur_len_s;
  logic        rsp_beat_s;
  logic        last_beat_s;

  // Packs address and length into the command format; unused bits stay 0.
  function automatic logic [C_PACKET_WIDTH-1:0] make_packet(input logic [63:0] addr,
                                                            input logic [35:0] len);
    logic [C_PACKET_WIDTH-1:0] pkt;
    pkt          = '0;
    pkt[127:64]  = addr;
    pkt[63:28]   = len;
    return pkt;
  endfunction

  // Number of data beats needed for a byte length, rounded up. Done in 37 bits
  // so a near-maximum length cannot overflow the rounding add.
  function automatic logic [36:0] beat_count(input logic [35:0] len);
    return ({1'b0, len} + BEAT_ROUND) >> C_BEAT_BYTES_LOG2;
  endfunction

  // Size of the next command and detection of the beat that completes a chunk.
  always_comb begin
    cur_len_s   = chunk_r;
    rsp_beat_s  = rsp_valid & rsp_accept;
    last_beat_s = 1'b0;
    if (remaining_r < chunk_r) begin
      cur_len_s = remaining_r;
    end else begin
      cur_len_s = chunk_r;
    end
    if (rsp_beat_s && ((beats_seen_r + 37'd1) == beats_expected_r)) begin
      last_beat_s = 1'b1;
    end else begin
      last_beat_s = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      addr_r           <= 64'd0;
      remaining_r      <= 36'd0;
      chunk_r          <= 36'd0;
      cur_len_r        <= 36'd0;
      beats_expected_r <= 37'd0;
      beats_seen_r     <= 37'd0;
      job_busy         <= 1'b0;
      job_done         <= 1'b0;
      job_error        <= 1'b0;
      cmd_valid        <= 1'b0;
      cmd_payload      <= '0;
    end else begin
      job_done  <= 1'b0;
      job_error <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (job_start) begin
            if ((job_total_len == 36'd0) || (job_chunk_len == 36'd0)) begin
              job_error <= 1'b1;
            end else begin
              addr_r      <= job_base_addr;
              remaining_r <= job_total_len;
              chunk_r     <= job_chunk_len;
              job_busy    <= 1'b1;
              state_r     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // First cycle in the state loads the packet; it then stays frozen
          // until the handshake.
          if (!cmd_valid) begin
            cmd_valid   <= 1'b1;
            cmd_payload <= make_packet(addr_r, cur_len_s);
            cur_len_r   <= cur_len_s;
          end else if (cmd_accept) begin
            cmd_valid        <= 1'b0;
            beats_expected_r <= beat_count(cur_len_r);
            beats_seen_r     <= 37'd0;
            addr_r           <= addr_r + {28'd0, cur_len_r};
            remaining_r      <= remaining_r - cur_len_r;
            state_r          <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_beat_s) begin
            beats_seen_r <= beats_seen_r + 37'd1;
          end
          if (last_beat_s) begin
            if (remaining_r == 36'd0) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          job_done <= 1'b1;
          job_busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          cmd_valid <= 1'b0;
          job_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ingress_command_sequencer.md
Name: ingress_command_sequencer

Overview:
- Sits directly upstream of the ingress interface and drives its ext_input command port.
- Takes one job (base address, total byte length, chunk size) and breaks it into a series of 128-bit read-command packets, one chunk per packet.
- Issues one command at a time, then snoops the ingress interface's ext_output handshake, counting returned 16-byte beats until the chunk is fully delivered.
- Advances the address and repeats until the job is exhausted, then pulses done.

Parameters:
- C_PACKET_WIDTH, 128, command packet width; must be >= 128.
- C_BEAT_BYTES_LOG2, 4, log2 of bytes per returned data beat (16 B).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- job_start  in  1  one-cycle pulse; sampled only in ST_IDLE
- job_base_addr  in  64  first byte address of job
- job_total_len  in  36  total bytes to fetch
- job_chunk_len  in  36  maximum bytes per command
- job_busy  out  1  high from accepted start until done pulse
- job_done  out  1  one-cycle pulse when last chunk fully returned
- job_error  out  1  one-cycle pulse on rejected start
- cmd_valid  out  1  command packet valid (to ext_input_valid)
- cmd_accept  in  1  command accepted (from ext_input_accept)
- cmd_payload  out  C_PACKET_WIDTH  [127:64]=address, [63:28]=length, [27:0]=0, upper bits above 127 = 0
- rsp_valid  in  1  snooped ext_output_valid
- rsp_accept  in  1  snooped ext_output_accept

Behaviour:
- Reset is synchronous, active-high, on clk. All outputs reset to 0; state = ST_IDLE; internal address, remaining, chunk and beat counters = 0.
- States: ST_IDLE, ST_ISSUE, ST_WAIT_RSP, ST_DONE (one-hot).
- ST_IDLE, on job_start:
  - If job_total_len==0 or job_chunk_len==0: pulse job_error next cycle and stay in ST_IDLE.
  - Otherwise latch addr=job_base_addr, remaining=job_total_len, chunk=job_chunk_len; set job_busy=1; go to ST_ISSUE.
  - job_start outside ST_IDLE is ignored.
- ST_ISSUE:
  - cur_len = min(chunk, remaining).
  - cmd_payload is registered and holds addr and cur_len while cmd_valid=1.
  - cmd_valid is asserted one cycle after entry and held until cmd_valid & cmd_accept.
  - Payload must not change while cmd_valid is high.
  - On the handshake:
    - cmd_valid <= 0
    - beats_expected = (cur_len + 2^C_BEAT_BYTES_LOG2 - 1) >> C_BEAT_BYTES_LOG2, computed 37-bit, no overflow
    - beats_seen = 0
    - addr += cur_len (64-bit, wraps modulo 2^64)
    - remaining -= cur_len
    - go to ST_WAIT_RSP
- ST_WAIT_RSP:
  - Each cycle with rsp_valid & rsp_accept increments beats_seen.
  - On the beat making beats_seen == beats_expected: if remaining==0 go to ST_DONE, else go to ST_ISSUE.
  - There is no turnaround bubble beyond the registered cmd_valid.
- ST_DONE: pulse job_done for one cycle, drop job_busy in the same cycle, return to ST_IDLE.
- Snooped beats seen in ST_IDLE or ST_ISSUE are ignored and not counted.
- Extra beats after the count is reached are ignored.
- A final partial chunk is supported, e.g. total=100, chunk=64 gives commands of 64 then 36 bytes.
- Lengths that are not beat multiples round the beat count up (36 B -> 3 beats).
- rst mid-job: immediate return to ST_IDLE, cmd_valid=0, job_busy=0, no job_done or job_error pulse. A command already accepted downstream is not tracked.
- Latency: job_start to first cmd_valid = 2 cycles. Last beat to job_done = 2 cycles.
- Stalls: cmd_accept held low stalls indefinitely with payload stable. No timeout.

Test Plan:
- Single chunk. base=0x1000, total=64, chunk=256; accept immediately; return 4 beats. Expect one command with payload[127:64]=0x1000 and [63:28]=64, then job_done exactly one cycle after state exit, job_busy low after.
- Multi-chunk with remainder. base=0x2000, total=100, chunk=64. Expect commands (0x2000, 64) after 4 beats, then (0x2040, 36) with 3 beats, then job_done. Exactly 2 commands.
- Backpressure. Hold cmd_accept low 10 cycles. Expect cmd_valid and cmd_payload stable all 10 cycles, exactly one handshake.
- Bad config. job_start with total=0, then with chunk=0. Expect a job_error pulse each time, no cmd_valid, job_busy stays 0.
- Snoop filtering. Drive rsp_valid&rsp_accept in ST_IDLE and ST_ISSUE, and interleave rsp_valid without accept during ST_WAIT_RSP. Expect only qualified ST_WAIT_RSP beats counted; next command issues after exactly beats_expected.
- Reset mid-job. Assert rst during ST_WAIT_RSP of chunk 2 of 3. Expect all outputs 0 the next cycle and no job_done. A new job_start then runs cleanly from its own base address.
